// File: rtl/rv_pkg.sv
// Shared RV32I constants and fetch-side types used by the fetch stage and the core.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  function automatic logic is_system(input logic [31:0] word);
    return word[6:0] == OPC_SYS;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} with occupancy count and synchronous flush.
module fetch_queue
  import rv_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int AW     = $clog2(QDEPTH),
  localparam int CW     = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wr_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(QDEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; a simultaneous pop frees the head slot being overwritten when full.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(do_push && full && !do_pop));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited sequential prefetch into a small queue,
// with redirect flush of stale in-flight responses and halt after a SYSTEM opcode.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_t  state, state_next;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] outstanding, outstanding_next, drop_cnt, q_count;
  logic          run, hold, credit_ok, req_fire, rsp_keep, pop, q_empty;
  fetch_entry_t  q_head, q_wr;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // run gates the first request until one clock after reset release.
  // hold keeps a stalled request asserted even if the credit or state changes under it.
  assign credit_ok     = ({1'b0, outstanding} + {1'b0, q_count}) < SW'(QDEPTH);
  assign mem_req_valid = run && !redirect_valid && ((state == ST_FETCH && credit_ok) || hold);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Kept responses all belong to the current stream, so the oldest one sits
  // exactly `outstanding` words behind the next fetch address.
  assign rsp_pc   = fetch_pc - {{(30 - CW){1'b0}}, outstanding, 2'b00};
  assign rsp_keep = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign q_wr     = '{pc: rsp_pc, instr: mem_rsp_data};

  assign instr_valid = !q_empty;
  assign instr       = instr_valid ? q_head.instr : NOP;
  assign instr_pc    = instr_valid ? q_head.pc : fetch_pc;
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (rsp_keep),
    .wr_entry (q_wr),
    .pop      (pop),
    .head     (q_head),
    .count    (q_count),
    .empty    (q_empty)
  );

  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !mem_rsp_valid)      outstanding_next = outstanding + 1'b1;
    else if (!req_fire && mem_rsp_valid) outstanding_next = outstanding - 1'b1;
  end

  always_comb begin
    state_next = state;
    if (redirect_valid)                      state_next = ST_FETCH;
    else if (pop && is_system(q_head.instr)) state_next = ST_HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      run         <= 1'b0;
      hold        <= 1'b0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      run         <= 1'b1;
      hold        <= mem_req_valid && !mem_req_ready;
      if (redirect_valid) begin
        // Everything still in flight after this cycle is stale.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (mem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: memory with in-order variable latency and a stream-level model.
module tb_instr_fetch;
  import rv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .NOP(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

  req_t        pending[$];
  ent_t        qm[$];
  logic [31:0] pc_log[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, epoch = 0;
  logic [31:0] req_pc, exp_pc, ecall_addr = 32'h8000_0000, first_target, force_target = 32'h0;
  bit          halted, prev_stall, skip_req, want_first, wrap_seen;
  bit          redir_on_rsp = 0, force_redir = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, irdy_pct = 100, redir_pct = 0;
  int          first_req_cyc, first_vld_cyc, halt_req_cnt;
  bit          last_req_vld, last_instr_vld;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == ecall_addr) ? 32'h0000_0073 : a;
  endfunction

  // Entered and left at a negative clock edge.
  task automatic do_reset();
    reset = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    #1;
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_instr_nop", instr, NOP_INSTR);
    check_eq("rst_instr_pc", instr_pc, RESET_PC);
    pending.delete(); qm.delete(); pc_log.delete();
    epoch++;
    req_pc = RESET_PC; exp_pc = RESET_PC;
    halted = 0; prev_stall = 0; skip_req = 1;
    want_first = 1; first_target = RESET_PC;
    first_req_cyc = -1; first_vld_cyc = -1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs at the negedge, check outputs, advance the model.
  task automatic step();
    bit rsp_now, redir, fire, popc, exp_req;
    logic [31:0] tgt;
    req_t r;
    rsp_now = pending.size() > 0 && pending[0].due <= cyc;
    mem_rsp_valid = rsp_now;
    mem_rsp_data  = rsp_now ? mem_word(pending[0].addr) : $urandom;
    mem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready   = ($urandom_range(99) < irdy_pct);
    redir = force_redir || (redir_on_rsp && rsp_now) || ($urandom_range(99) < redir_pct);
    tgt = (force_redir || redir_on_rsp) ? force_target : ($urandom & 32'h0000_0FFF);
    if (redir) begin force_redir = 0; redir_on_rsp = 0; end
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom;
    #1;
    check_eq("instr_valid", instr_valid, qm.size() > 0);
    if (qm.size() > 0) begin
      check_eq("instr", instr, qm[0].word);
      check_eq("instr_pc", instr_pc, qm[0].pc);
    end else begin
      check_eq("instr_nop", instr, NOP_INSTR);
    end
    exp_req = (!halted && !redir && (pending.size() + qm.size() < QDEPTH)) || (prev_stall && !redir);
    if (!skip_req) check_eq("req_valid", mem_req_valid, exp_req);
    if (mem_req_valid) check_eq("req_addr", mem_req_addr, req_pc);
    if (halted && mem_req_valid) halt_req_cnt++;
    if (first_req_cyc < 0 && mem_req_valid) first_req_cyc = cyc;
    if (first_vld_cyc < 0 && instr_valid) first_vld_cyc = cyc;
    last_req_vld = mem_req_valid;
    last_instr_vld = instr_valid;

    fire = mem_req_valid && mem_req_ready;
    popc = instr_valid && instr_ready && !redir && qm.size() > 0;
    if (popc) begin
      if (want_first) begin
        check_eq("redir_first_pc", instr_pc, first_target);
        want_first = 0;
      end
      check_eq("stream_pc", qm[0].pc, exp_pc);
      pc_log.push_back(qm[0].pc);
      if (qm[0].pc == 32'h0) wrap_seen = 1;
      exp_pc += 32'd4;
      if (qm[0].word[6:0] == 7'b1110011) halted = 1;
      void'(qm.pop_front());
    end
    if (rsp_now) begin
      r = pending.pop_front();
      if (r.epoch == epoch && !redir) qm.push_back('{pc: r.addr, word: mem_word(r.addr)});
    end
    if (fire) begin
      pending.push_back('{addr: mem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), epoch: epoch});
      req_pc += 32'd4;
    end
    if (redir) begin
      epoch++;
      qm.delete();
      req_pc = {tgt[31:2], 2'b00};
      exp_pc = req_pc;
      halted = 0;
      want_first = 1;
      first_target = req_pc;
    end
    prev_stall = mem_req_valid && !mem_req_ready && !redir;
    skip_req = 0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Zero-wait memory, core always ready.
    run(20);
    check_eq("first_req_cycle_le1", first_req_cyc <= 1, 1'b1);
    check_eq("first_latency", first_vld_cyc - first_req_cyc, 32'd2);
    check_eq("pc_log_size", pc_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < pc_log.size(); i++)
      check_eq($sformatf("seq_pc%0d", i), pc_log[i], RESET_PC + 32'(4 * i));

    // Core stalls: queue plus in-flight limited by credit.
    irdy_pct = 0;
    run(6);
    check_eq("stall_instr_valid", last_instr_vld, 1'b1);
    check_eq("stall_no_req", last_req_vld, 1'b0);
    irdy_pct = 100;
    run(10);

    // Three-cycle memory, redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30 && pending.size() != 2; i++) step();
    check_eq("two_inflight_reached", pending.size(), 32'd2);
    force_target = 32'h0000_0100; force_redir = 1;
    run(15);
    check_eq("redir_100_delivered", want_first, 1'b0);

    // Redirect coinciding with a response.
    lat_min = 2; lat_max = 2;
    force_target = 32'h0000_0202; redir_on_rsp = 1;
    for (int i = 0; i < 20 && redir_on_rsp; i++) step();
    check_eq("redir_on_rsp_fired", redir_on_rsp, 1'b0);
    run(15);
    check_eq("redir_200_delivered", want_first, 1'b0);

    // ecall halts prefetch until a redirect.
    lat_min = 1; lat_max = 2;
    ecall_addr = 32'h0000_0308;
    force_target = 32'h0000_0300; force_redir = 1;
    for (int i = 0; i < 40 && !halted; i++) step();
    check_eq("ecall_halted", halted, 1'b1);
    run(2);
    halt_req_cnt = 0;
    run(10);
    check_eq("halt_no_req", halt_req_cnt, 32'd0);
    force_target = 32'h0000_0040; force_redir = 1;
    run(15);
    check_eq("resume_40_delivered", want_first, 1'b0);
    ecall_addr = 32'h8000_0000;

    // Address wrap at the top of memory.
    wrap_seen = 0;
    force_target = 32'hFFFF_FFF8; force_redir = 1;
    run(20);
    check_eq("wrap_seen", wrap_seen, 1'b1);

    // Reset mid-stream with the queue full.
    irdy_pct = 0;
    run(8);
    check_eq("prereset_full", last_instr_vld, 1'b1);
    do_reset();
    irdy_pct = 100;
    run(15);
    check_eq("restart_delivered", want_first, 1'b0);

    // Randomized traffic.
    lat_min = 1; lat_max = 4; rdy_pct = 60; irdy_pct = 60; redir_pct = 4;
    run(2000);
    redir_pct = 0; irdy_pct = 100; rdy_pct = 100;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the single-cycle RV32I core.
- Issues sequential word reads to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers fetched words in a small queue and presents them with their PC to the core over a valid/ready channel.
- Handles core-initiated redirects (jal/jalr/taken branch) by flushing and discarding stale in-flight responses; halts prefetch after a SYSTEM opcode is delivered.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, instruction queue entries (power of two, >= 2); also the cap on queued plus outstanding words.
- NOP, 32'h0000_0013, value driven on instr when instr_valid is low (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  word-aligned read address.
- mem_rsp_valid  in  1  response data valid; always accepted, in request order.
- mem_rsp_data  in  32  response word.
- instr_valid  out  1  queue head valid.
- instr  out  32  queue head instruction, or NOP when not valid.
- instr_pc  out  32  address of queue head.
- instr_ready  in  1  core consumes head this cycle.
- redirect_valid  in  1  core requests a non-sequential PC.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored.

Behaviour:
- Reset values: fetch_pc=RESET_PC, state=FETCH, queue empty, outstanding=0, drop_cnt=0, mem_req_valid=0, instr_valid=0, instr=NOP, instr_pc=RESET_PC.
- States:
  - FETCH: issue requests.
  - HALT: no new requests; entered when a head word with opcode 7'b1110011 is consumed.
  - HALT -> FETCH only on redirect_valid.
- Issue condition: mem_req_valid = (state==FETCH) && !redirect_valid && (outstanding + count < QDEPTH).
  - mem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (32-bit wrap from FFFF_FFFC to 0), outstanding+1.
- mem_req_valid must not drop or change address while ready is low, except in the redirect cycle, where it is withdrawn.
- Response handling:
  - If drop_cnt>0: discard the response, drop_cnt-1.
  - Otherwise: push {data, pc_of_request} into the queue.
  - outstanding-1 in both cases.
  - The credit rule guarantees the queue never overflows; overflow is an assertion failure.
- Outputs are registered from the queue. A response is visible on instr_valid no earlier than the cycle after mem_rsp_valid (no bypass).
- Pop on instr_valid && instr_ready. Push and pop in the same cycle are legal at any occupancy.
- Redirect (highest priority):
  - Queue flushed, so instr_valid=0 next cycle.
  - Any pop in that cycle is ignored.
  - fetch_pc <= {redirect_pc[31:2],2'b00}; state <= FETCH.
  - drop_cnt <= outstanding after counting a request accepted this cycle, minus a response arriving this cycle. Such a response is itself discarded.
  - First request at the new address is issued the following cycle.
- Redirect while drop_cnt>0: accumulate per the rule above; never lose an in-flight count.
- Latency with 0-wait memory (ready=1, response 1 cycle after accept):
  - Reset released at cycle 0 -> request at cycle 0 or 1 -> instr_valid two cycles after the request.
  - Steady state: one instruction per cycle.
- Reset mid-operation clears everything immediately. Late responses after reset release are not the block's concern; memory is reset by the same signal.

Decomposition:
- Shared package rv_pkg: opcode constants (OPC_SYS etc., shared with the core) and the NOP constant.
- One sub-module: fetch_queue, a synchronous FIFO with count output and flush input, storing {pc, instr}.
- The FSM, credit counter and drop counter live in instr_fetch.

Test Plan:
- Reset release, 0-wait memory returning data=addr, ready=1 -> instr_pc sequence 0,4,8,C, one per cycle after the first; instr=NOP before first valid.
- instr_ready held low for 5 cycles -> at most QDEPTH words queued and outstanding; mem_req_valid=0 when full; order preserved once ready=1.
- Memory with 3-cycle response latency, redirect_pc=0x100 while 2 requests are in flight -> both stale responses dropped; next delivered instr_pc=0x100.
- Redirect coinciding with a response and with mem_req accept -> drop_cnt accounts for both; no stale word is ever delivered.
- Deliver word 0x00000073 (ecall) -> state HALT, mem_req_valid=0 indefinitely; redirect to 0x40 resumes fetch at 0x40.
- Assert reset mid-stream with the queue full -> instr_valid=0 and mem_req_valid=0 immediately; fetch restarts at RESET_PC.
